// File: rtl/l1_data_cache_ctrl.sv
// l1_data_cache_ctrl: sequencing controller for a direct-mapped, write-back,
// write-allocate L1 data cache. It holds tag/valid/dirty state, drives an
// external word-addressed data array and moves lines to and from memory
// over a word-serial req/ack handshake.
module l1_data_cache_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int WORD_W   = 16,
    parameter int INDEX_W  = 11,
    parameter int OFFSET_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic                cpu_ready,
    output logic                cpu_done,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                cpu_hit,
    output logic [INDEX_W-1:0]  dc_index,
    output logic [OFFSET_W-1:0] dc_word,
    output logic                dc_we,
    output logic [WORD_W-1:0]   dc_wdata,
    input  logic [WORD_W-1:0]   dc_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        REFILL,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [INDEX_W-1:0]    idx_q, idx_d;
    logic [OFFSET_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [OFFSET_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;
    logic                  hit_q, hit_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;

    logic [TAG_W-1:0]      tag_mem [LINES];
    logic                  tag_we;
    logic                  lookup_hit;

    assign lookup_hit = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
    assign cpu_rdata  = rdata_q;

    // Control and status registers; reset aborts any transfer in flight.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag storage, written once per completed refill.
    // NOTE: the tag array has no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[idx_q] <= tag_q;
        end
    end

    // Next-state logic and all outputs for the request sequencer.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        tag_d     = tag_q;
        idx_d     = idx_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        hit_d     = hit_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_we    = 1'b0;
        cpu_ready = 1'b0;
        cpu_done  = 1'b0;
        cpu_hit   = 1'b0;
        dc_index  = idx_q;
        dc_word   = word_q;
        dc_we     = 1'b0;
        dc_wdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    we_d    = cpu_we;
                    tag_d   = cpu_addr[ADDR_W-1 -: TAG_W];
                    idx_d   = cpu_addr[OFFSET_W +: INDEX_W];
                    word_d  = cpu_addr[OFFSET_W-1:0];
                    wdata_d = cpu_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d = lookup_hit;
                cnt_d = '0;
                if (lookup_hit) begin
                    if (we_q) begin
                        dc_we          = 1'b1;
                        dc_wdata       = wdata_q;
                        dirty_d[idx_q] = 1'b1;
                    end else begin
                        rdata_d = dc_rdata;
                    end
                    state_d = DONE;
                end else if (valid_q[idx_q] && dirty_q[idx_q]) begin
                    state_d = WB;
                end else begin
                    state_d = REFILL;
                end
            end
            WB: begin
                // Victim words stream out of the data array at the old tag.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[idx_q], idx_q, cnt_q};
                dc_word   = cnt_q;
                mem_wdata = dc_rdata;
                if (mem_ack) begin
                    if (cnt_q == LAST_WORD) begin
                        dirty_d[idx_q] = 1'b0;
                        cnt_d          = '0;
                        state_d        = REFILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, idx_q, cnt_q};
                dc_word  = cnt_q;
                if (mem_ack) begin
                    // Store-miss data replaces the fetched word in flight.
                    dc_we    = 1'b1;
                    dc_wdata = (we_q && cnt_q == word_q) ? wdata_q : mem_rdata;
                    if (!we_q && cnt_q == word_q) begin
                        rdata_d = mem_rdata;
                    end
                    if (cnt_q == LAST_WORD) begin
                        tag_we         = 1'b1;
                        valid_d[idx_q] = 1'b1;
                        dirty_d[idx_q] = we_q;
                        cnt_d          = '0;
                        state_d        = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                cpu_done = 1'b1;
                cpu_hit  = hit_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
